// File: rtl/matrix_pkg.sv
// Shared 4x4 key-matrix definitions: scanner FSM encoding, active-low row
// drive patterns and column priority helper, reusable by the display driver.
package matrix_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   localparam logic [3:0] ROW_PAT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   function automatic logic [3:0] row_pattern(input logic [1:0] r);
      return ROW_PAT[r];
   endfunction

   // Lowest-numbered sensed column wins when several keys share a row.
   function automatic logic [1:0] lowest_low(input logic [3:0] cols);
      logic [1:0] idx;
      if (!cols[0]) begin
         idx = 2'd0;
      end else if (!cols[1]) begin
         idx = 2'd1;
      end else if (!cols[2]) begin
         idx = 2'd2;
      end else if (!cols[3]) begin
         idx = 2'd3;
      end else begin
         idx = 2'd0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/debounce_counter.sv
// 8-bit run-length counter shared by the press and release debounce phases;
// last flags that the next increment completes a run of DEB_CYCLES samples.
module debounce_counter
   import matrix_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam logic [7:0] LAST_VAL = 8'(DEB_CYCLES - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: clear has priority over increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 8'd0;
      end else if (inc) begin
         count_d = count_q + 8'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == LAST_VAL);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows, debounces the first key found,
// reports it once, then waits for a debounced release before scanning on.
module keypad_scanner
   import matrix_pkg::*;
#(
   parameter int unsigned ROW_DWELL  = 4,
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic       scan_clk,
   input  logic       rst_n,
   output logic [3:0] key_row,
   input  logic [3:0] key_col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [7:0] DWELL_LAST = 8'(ROW_DWELL - 1);

   state_t     state_q, state_d;
   logic [1:0] row_q, row_d;
   logic [1:0] col_q, col_d;
   logic [7:0] dwell_q, dwell_d;
   logic [3:0] key_row_q, key_row_d;
   logic [3:0] key_code_q, key_code_d;
   logic       key_valid_q, key_valid_d;
   logic       key_held_q, key_held_d;
   logic       cnt_clr_s;
   logic       cnt_inc_s;
   logic       cnt_last_s;
   logic       col_bit_s;

   assign col_bit_s = key_col[col_q];

   debounce_counter #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk   (scan_clk),
      .rst_n (rst_n),
      .clr   (cnt_clr_s),
      .inc   (cnt_inc_s),
      .last  (cnt_last_s)
   );

   // Next-state and output decode. A run completes on the edge that samples
   // its DEB_CYCLES-th matching value; the triggering sample is not counted.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      dwell_d     = dwell_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      cnt_clr_s   = 1'b0;
      cnt_inc_s   = 1'b0;
      case (state_q)
         ST_SCAN: begin
            cnt_clr_s = 1'b1;
            if (dwell_q == DWELL_LAST) begin
               dwell_d = 8'd0;
               if (key_col == 4'b1111) begin
                  row_d = row_q + 2'd1;
               end else begin
                  col_d   = lowest_low(key_col);
                  state_d = ST_DEBOUNCE;
               end
            end else begin
               dwell_d = dwell_q + 8'd1;
            end
         end
         ST_DEBOUNCE: begin
            if (!col_bit_s) begin
               if (cnt_last_s) begin
                  key_code_d  = {row_q, col_q};
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  state_d     = ST_HOLD;
                  cnt_clr_s   = 1'b1;
               end else begin
                  cnt_inc_s = 1'b1;
               end
            end else begin
               state_d   = ST_SCAN;
               row_d     = row_q + 2'd1;
               dwell_d   = 8'd0;
               cnt_clr_s = 1'b1;
            end
         end
         ST_HOLD: begin
            cnt_clr_s = 1'b1;
            if (col_bit_s) begin
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_RELEASE: begin
            if (col_bit_s) begin
               if (cnt_last_s) begin
                  key_held_d = 1'b0;
                  state_d    = ST_SCAN;
                  row_d      = row_q + 2'd1;
                  dwell_d    = 8'd0;
                  cnt_clr_s  = 1'b1;
               end else begin
                  cnt_inc_s = 1'b1;
               end
            end else begin
               state_d   = ST_HOLD;
               cnt_clr_s = 1'b1;
            end
         end
         default: begin
            state_d    = ST_SCAN;
            row_d      = 2'd0;
            dwell_d    = 8'd0;
            key_held_d = 1'b0;
            cnt_clr_s  = 1'b1;
         end
      endcase
      key_row_d = row_pattern(row_d);
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge scan_clk) begin
      if (!rst_n) begin
         state_q     <= ST_SCAN;
         row_q       <= 2'd0;
         col_q       <= 2'd0;
         dwell_q     <= 8'd0;
         key_row_q   <= 4'b1110;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         dwell_q     <= dwell_d;
         key_row_q   <= key_row_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign key_row   = key_row_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model:
// table of single-press vectors plus hand-written bounce/glitch/reset sequences.
module tb_keypad_scanner;

   logic        scan_clk;
   logic        rst_n;
   logic [3:0]  key_row;
   logic [3:0]  key_col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] pressed;
      logic [3:0]  exp_code;
      logic [3:0]  exp_row;
      int          accept_obs;
   } vec_t;

   vec_t       vecs [7];
   logic [3:0] rows [4];

   keypad_scanner #(
      .ROW_DWELL  (4),
      .DEB_CYCLES (16)
   ) dut (
      .scan_clk  (scan_clk),
      .rst_n     (rst_n),
      .key_row   (key_row),
      .key_col   (key_col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial scan_clk = 1'b0;
   always #5 scan_clk = ~scan_clk;

   // Pulled-up columns; a pressed key on the driven (low) row pulls its column low.
   always_comb begin
      key_col = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge scan_clk);
      #1;
   endtask

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      pressed = 16'h0000;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // n cycles with no key_valid and a fixed key_held level.
   task automatic run_quiet(input int n, input logic held);
      for (int i = 0; i < n; i++) begin
         tick();
         check1("no_valid", key_valid, 1'b0);
         check1("held_level", key_held, held);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      pressed = 16'h0000;
      rows[0] = 4'b1110;
      rows[1] = 4'b1101;
      rows[2] = 4'b1011;
      rows[3] = 4'b0111;
      // Acceptance observed 4*row + 20 cycles after reset release.
      vecs[0] = '{16'h0200, 4'h9, 4'b1011, 28};
      vecs[1] = '{16'h000A, 4'h1, 4'b1110, 20};
      vecs[2] = '{16'h8000, 4'hF, 4'b0111, 32};
      vecs[3] = '{16'h0001, 4'h0, 4'b1110, 20};
      vecs[4] = '{16'h4010, 4'h4, 4'b1101, 24};
      vecs[5] = '{16'hF000, 4'hC, 4'b0111, 32};
      vecs[6] = '{16'h0040, 4'h6, 4'b1101, 24};

      // Reset values and idle scan sequence.
      do_reset();
      check4("rst_row", key_row, 4'b1110);
      check4("rst_code", key_code, 4'h0);
      check1("rst_valid", key_valid, 1'b0);
      check1("rst_held", key_held, 1'b0);
      for (int k = 1; k < 40; k++) begin
         tick();
         check4("idle_row", key_row, rows[(k / 4) % 4]);
         check1("idle_valid", key_valid, 1'b0);
      end

      // Table of clean presses: exact acceptance cycle, code, single pulse.
      foreach (vecs[i]) begin
         do_reset();
         pressed = vecs[i].pressed;
         run_quiet(vecs[i].accept_obs - 1, 1'b0);
         tick();
         check1("vec_valid", key_valid, 1'b1);
         check4("vec_code", key_code, vecs[i].exp_code);
         check1("vec_held", key_held, 1'b1);
         check4("vec_row", key_row, vecs[i].exp_row);
         tick();
         check1("vec_pulse_end", key_valid, 1'b0);
         check4("vec_code_keep", key_code, vecs[i].exp_code);
      end

      // Clean press then release: scanning resumes at the following row.
      do_reset();
      pressed = 16'h0200;
      run_quiet(27, 1'b0);
      tick();
      check1("rel_valid", key_valid, 1'b1);
      pressed = 16'h0000;
      run_quiet(16, 1'b1);
      tick();
      check1("rel_held_clr", key_held, 1'b0);
      check4("rel_row3", key_row, 4'b0111);
      check4("rel_code_keep", key_code, 4'h9);
      for (int k = 0; k < 3; k++) begin
         tick();
         check4("rel_row3_dwell", key_row, 4'b0111);
      end
      tick();
      check4("rel_row0", key_row, 4'b1110);

      // Bouncing press: aborted debounce moves on, later clean run accepts once.
      do_reset();
      pressed = 16'h0040;
      run_quiet(13, 1'b0);
      pressed = 16'h0000;
      tick();
      check4("bounce_next_row", key_row, 4'b1011);
      check1("bounce_no_valid", key_valid, 1'b0);
      pressed = 16'h0040;
      run_quiet(31, 1'b0);
      tick();
      check1("bounce_valid", key_valid, 1'b1);
      check4("bounce_code", key_code, 4'h6);
      tick();
      check1("bounce_pulse_end", key_valid, 1'b0);

      // Reset on the 10th debounce cycle aborts the press.
      do_reset();
      pressed = 16'h0001;
      run_quiet(13, 1'b0);
      rst_n = 1'b0;
      tick();
      check4("abort_row", key_row, 4'b1110);
      check1("abort_held", key_held, 1'b0);
      check1("abort_valid", key_valid, 1'b0);
      rst_n   = 1'b1;
      pressed = 16'h0000;
      run_quiet(30, 1'b0);

      // Reset while holding clears held and code.
      do_reset();
      pressed = 16'h8000;
      run_quiet(31, 1'b0);
      tick();
      check1("hold_valid", key_valid, 1'b1);
      rst_n = 1'b0;
      tick();
      check4("hold_rst_code", key_code, 4'h0);
      check1("hold_rst_held", key_held, 1'b0);
      check4("hold_rst_row", key_row, 4'b1110);
      rst_n   = 1'b1;
      pressed = 16'h0000;

      // Release glitch: high 8, low 1, then a full release run.
      do_reset();
      pressed = 16'h0200;
      run_quiet(27, 1'b0);
      tick();
      check1("glitch_valid", key_valid, 1'b1);
      pressed = 16'h0000;
      run_quiet(8, 1'b1);
      pressed = 16'h0200;
      run_quiet(1, 1'b1);
      pressed = 16'h0000;
      run_quiet(16, 1'b1);
      tick();
      check1("glitch_held_clr", key_held, 1'b0);
      check1("glitch_no_valid", key_valid, 1'b0);
      check4("glitch_code_keep", key_code, 4'h9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
